// File: rtl/fetch_unit.sv
// PC generator and instruction-fetch front end: one bus request per instruction,
// redirects during an outstanding request are parked and replayed after its response.
module fetch_unit #(
  parameter int unsigned         XLEN     = 64,
  parameter logic [XLEN-1:0]     RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      PCWrite,
  input  logic            PCSel,
  input  logic [XLEN-1:0] pc_target,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  output logic            imem_wait,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_instr
);

  typedef enum logic {FETCH, HOLD} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic              pend_q;
  logic [XLEN-1:0]   pend_tgt_q;
  logic [31:0]       buf_instr_q;

  logic              stream;
  logic              deliver;
  logic [XLEN-1:0]   pc_adv_d;

  assign stream   = (PCWrite == 2'b00);
  assign deliver  = (state_q == FETCH) && iresp_data_ok && !pend_q;
  assign pc_adv_d = PCSel ? pc_target : pc_q + XLEN'(4);

  // Outputs are forced low for the whole time reset is held, not just after the first edge.
  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = '0;
    imem_wait  = 1'b0;
    f_valid    = 1'b0;
    f_pc       = '0;
    f_instr    = '0;
    if (resetn) begin
      ireq_addr = pc_q;
      f_pc      = pc_q;
      if (state_q == FETCH) begin
        ireq_valid = 1'b1;
        f_valid    = deliver;
        imem_wait  = !deliver;
        f_instr    = iresp_data;
      end else begin
        f_valid    = 1'b1;
        f_instr    = buf_instr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      buf_instr_q <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (!iresp_data_ok) begin
            if (PCSel) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= pc_target;
            end
          end else if (pend_q) begin
            pc_q   <= pend_tgt_q;
            pend_q <= 1'b0;
          end else if (stream) begin
            pc_q <= pc_adv_d;
          end else begin
            buf_instr_q <= iresp_data;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (stream) begin
            pc_q    <= pc_adv_d;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: instructions the F register should accept are queued
// when stimulus is driven and matched against f_pc/f_instr when the DUT hands them over.
module tb_fetch_unit;

  localparam logic [63:0] RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  PCWrite;
  logic        PCSel;
  logic [63:0] pc_target;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        imem_wait;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;

  typedef struct packed { logic [63:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_unit #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .resetn(resetn), .PCWrite(PCWrite), .PCSel(PCSel), .pc_target(pc_target),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .imem_wait(imem_wait), .f_valid(f_valid), .f_pc(f_pc),
    .f_instr(f_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  // Drive one cycle's inputs; called right after a falling edge.
  task automatic setin(input logic [1:0] pcw, input logic sel, input logic [63:0] tgt,
                       input logic dok, input logic [31:0] data);
    PCWrite = pcw; PCSel = sel; pc_target = tgt; iresp_data_ok = dok; iresp_data = data;
  endtask

  task automatic apply_reset();
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // F register accepts an instruction when f_valid is high and the hazard unit streams.
  always begin
    @(negedge clk);
    #3;
    if (resetn && f_valid && PCWrite == 2'b00) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected got pc=%h instr=%h want none", f_pc, f_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (f_pc !== e.pc || f_instr !== e.instr) begin
          tests_failed++;
          $display("FAIL sb_deliver got pc=%h instr=%h want pc=%h instr=%h", f_pc, f_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    setin(2'b00, 1'b0, 64'h1234, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    tests_run++;
    if ({ireq_valid, imem_wait, f_valid, ireq_addr, f_pc, f_instr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b w=%b fv=%b a=%h pc=%h i=%h want all 0",
               ireq_valid, imem_wait, f_valid, ireq_addr, f_pc, f_instr);
    end
    @(negedge clk);
    resetn = 1'b1;
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    #1;
    tests_run++;
    if (ireq_valid !== 1'b1 || ireq_addr !== RST) begin
      tests_failed++;
      $display("FAIL reset_release got v=%b a=%h want 1 %h", ireq_valid, ireq_addr, RST);
    end
    @(negedge clk);
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      logic [63:0] a;
      a = RST + 64'(4 * i);
      setin(2'b00, 1'b0, '0, 1'b1, mem(a));
      sb.push_back('{pc: a, instr: mem(a)});
      #1;
      tests_run++;
      if (ireq_valid !== 1'b1 || ireq_addr !== a || imem_wait !== 1'b0 || f_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_%0d got v=%b a=%h w=%b fv=%b want 1 %h 0 1", i, ireq_valid, ireq_addr, imem_wait, f_valid, a);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      setin(2'b00, 1'b0, '0, 1'b0, 32'hDEAD_BEEF);
      #1;
      tests_run++;
      if (imem_wait !== 1'b1 || f_valid !== 1'b0 || ireq_addr !== RST || ireq_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL wait_%0d got w=%b fv=%b a=%h v=%b want 1 0 %h 1", i, imem_wait, f_valid, ireq_addr, ireq_valid, RST);
      end
      @(negedge clk);
    end
    setin(2'b00, 1'b0, '0, 1'b1, mem(RST));
    sb.push_back('{pc: RST, instr: mem(RST)});
    #1;
    tests_run++;
    if (imem_wait !== 1'b0 || f_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_deliver got w=%b fv=%b want 0 1", imem_wait, f_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      logic [63:0] a;
      a = RST + 64'(4 * i);
      setin(2'b00, 1'b0, '0, 1'b1, mem(a));
      sb.push_back('{pc: a, instr: mem(a)});
      @(negedge clk);
    end
    // Two redirects while waiting: the second target must win.
    setin(2'b00, 1'b1, RST + 64'h0F0, 1'b0, '0); @(negedge clk);
    setin(2'b00, 1'b1, RST + 64'h100, 1'b0, '0); @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0); @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b1, mem(RST + 64'h10));
    #1;
    tests_run++;
    if (f_valid !== 1'b0 || imem_wait !== 1'b1 || ireq_addr !== RST + 64'h10) begin
      tests_failed++;
      $display("FAIL discard got fv=%b w=%b a=%h want 0 1 %h", f_valid, imem_wait, ireq_addr, RST + 64'h10);
    end
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b1, mem(RST + 64'h100));
    sb.push_back('{pc: RST + 64'h100, instr: mem(RST + 64'h100)});
    #1;
    tests_run++;
    if (ireq_addr !== RST + 64'h100 || f_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL redirect_addr got a=%h fv=%b want %h 1", ireq_addr, f_valid, RST + 64'h100);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [63:0] a;
    a = RST + 64'h104;
    setin(2'b11, 1'b0, '0, 1'b1, mem(a));
    sb.push_back('{pc: a, instr: mem(a)});
    #1;
    tests_run++;
    if (f_valid !== 1'b1 || f_instr !== mem(a) || ireq_addr !== a) begin
      tests_failed++;
      $display("FAIL hold_enter got fv=%b i=%h a=%h want 1 %h %h", f_valid, f_instr, ireq_addr, mem(a), a);
    end
    @(negedge clk);
    setin(2'b01, 1'b0, '0, 1'b0, 32'hDEAD_BEEF);
    #1;
    tests_run++;
    if (ireq_valid !== 1'b0 || f_valid !== 1'b1 || f_instr !== mem(a) || imem_wait !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_1 got v=%b fv=%b i=%h w=%b want 0 1 %h 0", ireq_valid, f_valid, f_instr, imem_wait, mem(a));
    end
    @(negedge clk);
    setin(2'b11, 1'b1, RST + 64'h900, 1'b1, 32'hDEAD_BEEF);
    #1;
    tests_run++;
    if (ireq_valid !== 1'b0 || f_instr !== mem(a) || f_pc !== a) begin
      tests_failed++;
      $display("FAIL hold_2 got v=%b i=%h pc=%h want 0 %h %h", ireq_valid, f_instr, f_pc, mem(a), a);
    end
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    #1;
    tests_run++;
    if (ireq_valid !== 1'b1 || ireq_addr !== a + 64'd4) begin
      tests_failed++;
      $display("FAIL hold_exit got v=%b a=%h want 1 %h", ireq_valid, ireq_addr, a + 64'd4);
    end
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [63:0] a;
    a = RST + 64'h108;
    setin(2'b00, 1'b1, RST + 64'h200, 1'b1, mem(a));
    sb.push_back('{pc: a, instr: mem(a)});
    #1;
    tests_run++;
    if (f_valid !== 1'b1 || ireq_addr !== a) begin
      tests_failed++;
      $display("FAIL same_deliver got fv=%b a=%h want 1 %h", f_valid, ireq_addr, a);
    end
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    #1;
    tests_run++;
    if (ireq_addr !== RST + 64'h200 || imem_wait !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_target got a=%h w=%b want %h 1", ireq_addr, imem_wait, RST + 64'h200);
    end
    @(negedge clk);
    // No pending redirect was recorded, so this response is delivered, not discarded.
    setin(2'b00, 1'b0, '0, 1'b1, mem(RST + 64'h200));
    sb.push_back('{pc: RST + 64'h200, instr: mem(RST + 64'h200)});
    #1;
    tests_run++;
    if (f_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_nopend got fv=%b want 1", f_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [63:0] top, mis;
    top = 64'hFFFF_FFFF_FFFF_FFFC;
    mis = RST + 64'h302;
    setin(2'b00, 1'b1, top, 1'b1, mem(RST + 64'h204));
    sb.push_back('{pc: RST + 64'h204, instr: mem(RST + 64'h204)});
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b1, mem(top));
    sb.push_back('{pc: top, instr: mem(top)});
    @(negedge clk);
    setin(2'b00, 1'b1, mis, 1'b1, mem(64'h0));
    sb.push_back('{pc: 64'h0, instr: mem(64'h0)});
    #1;
    tests_run++;
    if (ireq_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL wrap got a=%h want 0", ireq_addr);
    end
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b1, mem(mis));
    sb.push_back('{pc: mis, instr: mem(mis)});
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    #1;
    tests_run++;
    if (ireq_addr !== mis + 64'd4) begin
      tests_failed++;
      $display("FAIL misaligned got a=%h want %h", ireq_addr, mis + 64'd4);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    setin(2'b00, 1'b1, RST + 64'h700, 1'b0, '0);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({ireq_valid, imem_wait, f_valid, ireq_addr, f_pc, f_instr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid got v=%b w=%b fv=%b a=%h pc=%h i=%h want all 0",
               ireq_valid, imem_wait, f_valid, ireq_addr, f_pc, f_instr);
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    setin(2'b00, 1'b0, '0, 1'b1, mem(RST));
    sb.push_back('{pc: RST, instr: mem(RST)});
    #1;
    tests_run++;
    if (ireq_addr !== RST || f_valid !== 1'b1 || imem_wait !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_restart got a=%h fv=%b w=%b want %h 1 0", ireq_addr, f_valid, imem_wait, RST);
    end
    @(negedge clk);
    setin(2'b00, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_redirect_pending();
    test_hold();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain got %0d left want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
